// File: rtl/mem_responder_6502.sv
// Memory-side responder for the byte-wide 6502 request interface: single reads and writes,
// 8-beat wrapping read bursts, and programmable wait states / beat gaps in front of a sync RAM.
module mem_responder_6502 #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 0,
    parameter int BEAT_GAP    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [23:0]           mem_addr,
    input  logic                  mem_en,
    input  logic                  mem_wr,
    input  logic                  mem_rburst,
    input  logic                  mem_wburst,
    input  logic [7:0]            mem_wdata,
    output logic                  mem_rdy,
    output logic [7:0]            mem_rdata,
    output logic [7:0]            mem_rdata0,
    output logic                  mem_rdata_load,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_GAP,
        S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic                  burst_q;
    logic [7:0]            wdata_q;
    logic [3:0]            cnt;
    logic [2:0]            beat;
    logic                  rd_pending;
    logic [3:0]            beat_sum;
    logic                  unused_inputs;

    // Write bursts run as single writes and high address bits alias, so these inputs are inert.
    assign unused_inputs = ^{mem_wburst, mem_addr};

    // Carry out of the 3-bit beat counter marks the last burst beat.
    assign beat_sum  = {1'b0, beat} + 4'd1;
    assign ram_addr  = {addr_q[ADDR_WIDTH-1:3], addr_q[2:0] + beat};
    assign ram_wdata = wdata_q;

    // A read strobes the cycle after its RAM issue; a write strobes in its access cycle (echo).
    assign mem_rdata_load = rd_pending | (ram_en & ram_we);

    always_comb begin
        mem_rdata0 = 8'h00;
        if (rd_pending)
            mem_rdata0 = ram_rdata;
        else if (ram_en && ram_we)
            mem_rdata0 = wdata_q;
    end

    // NOTE: all state below uses non-blocking assignments so every branch sees the
    // pre-edge values of ram_en/ram_we/beat regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            burst_q    <= 1'b0;
            wdata_q    <= 8'h00;
            cnt        <= 4'd0;
            beat       <= 3'd0;
            rd_pending <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            mem_rdy    <= 1'b1;
            mem_rdata  <= 8'h00;
        end else begin
            rd_pending <= ram_en & ~ram_we;
            if (mem_rdata_load)
                mem_rdata <= mem_rdata0;

            case (state)
                S_IDLE: begin
                    if (mem_en) begin
                        addr_q  <= mem_addr[ADDR_WIDTH-1:0];
                        wr_q    <= mem_wr;
                        burst_q <= mem_rburst & ~mem_wr;
                        wdata_q <= mem_wdata;
                        beat    <= 3'd0;
                        mem_rdy <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            state <= S_WAIT;
                            cnt   <= 4'(WAIT_STATES - 1);
                        end else begin
                            state  <= S_ACCESS;
                            ram_en <= 1'b1;
                            ram_we <= mem_wr;
                        end
                    end
                end

                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= S_ACCESS;
                        ram_en <= 1'b1;
                        ram_we <= wr_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                S_ACCESS: begin
                    if (wr_q) begin
                        state   <= S_IDLE;
                        ram_en  <= 1'b0;
                        ram_we  <= 1'b0;
                        mem_rdy <= 1'b1;
                    end else if (!burst_q || beat_sum[3]) begin
                        state  <= S_DONE;
                        ram_en <= 1'b0;
                    end else begin
                        beat <= beat_sum[2:0];
                        if (BEAT_GAP > 0) begin
                            state  <= S_GAP;
                            cnt    <= 4'(BEAT_GAP - 1);
                            ram_en <= 1'b0;
                        end
                    end
                end

                S_GAP: begin
                    if (cnt == 4'd0) begin
                        state  <= S_ACCESS;
                        ram_en <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    mem_rdy <= 1'b1;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder_6502.sv
// Bench for mem_responder_6502: three instances (plain, wait states, beat gap) each with a sync RAM,
// checked against a per-transaction timing/data model derived from the request rules.
module tb_mem_responder_6502;

    localparam int AW = 12;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NI-1:0][23:0]   addr_v;
    logic [NI-1:0]         en_v, wr_v, rb_v, wb_v;
    logic [NI-1:0][7:0]    wd_v;
    logic [NI-1:0]         rdy_v, load_v, ren_v, rwe_v;
    logic [NI-1:0][7:0]    rdata_v, rdata0_v, rwdata_v;
    logic [NI-1:0][AW-1:0] raddr_v;

    logic [7:0] exp_mem [NI][1 << AW];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [7:0] init_byte(input int g, input int i);
        return 8'((i * 7 + g * 53) ^ (i >> 4));
    endfunction

    function automatic int ws_of(input int g);
        return (g == 1) ? 2 : 0;
    endfunction

    function automatic int bg_of(input int g);
        return (g == 2) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        logic [7:0] rd_q;
        logic [7:0] ram [1 << AW];

        mem_responder_6502 #(
            .ADDR_WIDTH (AW),
            .WAIT_STATES(g == 1 ? 2 : 0),
            .BEAT_GAP   (g == 2 ? 1 : 0)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .mem_addr      (addr_v[g]),
            .mem_en        (en_v[g]),
            .mem_wr        (wr_v[g]),
            .mem_rburst    (rb_v[g]),
            .mem_wburst    (wb_v[g]),
            .mem_wdata     (wd_v[g]),
            .mem_rdy       (rdy_v[g]),
            .mem_rdata     (rdata_v[g]),
            .mem_rdata0    (rdata0_v[g]),
            .mem_rdata_load(load_v[g]),
            .ram_addr      (raddr_v[g]),
            .ram_en        (ren_v[g]),
            .ram_we        (rwe_v[g]),
            .ram_wdata     (rwdata_v[g]),
            .ram_rdata     (rd_q)
        );

        initial for (int i = 0; i < (1 << AW); i++) ram[i] = init_byte(g, i);

        always @(posedge clk) begin
            if (ren_v[g]) begin
                if (rwe_v[g]) ram[raddr_v[g]] <= rwdata_v[g];
                else          rd_q <= ram[raddr_v[g]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One transaction on instance g. drop_at: strobes after which mem_en is released (99 = hold
    // through completion). rst_at: strobe count at which reset is pulsed (-1 = never).
    task automatic run_txn(input int g, input logic [23:0] a, input logic wr, input logic bur,
                           input logic wbur, input logic [7:0] wd, input int drop_at, input int rst_at);
        int ws = ws_of(g);
        int bg = bg_of(g);
        int nb;
        int exp_off [8];
        logic [7:0] exp_d [8];
        logic [AW-1:0] a12;
        logic [AW-1:0] ak;
        int t, strobes, ens, wes;
        bit done;

        a12 = a[AW-1:0];
        nb  = (wr || !bur) ? 1 : 8;
        for (int k = 0; k < nb; k++) begin
            ak = (nb == 1) ? a12 : {a12[AW-1:3], 3'(a12[2:0] + 3'(k))};
            exp_off[k] = wr ? (1 + ws) : (2 + ws + k * (1 + bg));
            exp_d[k]   = wr ? wd : exp_mem[g][ak];
        end

        @(negedge clk);
        check("rdy_before_req", rdy_v[g], 1);
        addr_v[g] = a; wr_v[g] = wr; rb_v[g] = bur; wb_v[g] = wbur; wd_v[g] = wd; en_v[g] = 1'b1;

        t = 0; strobes = 0; ens = 0; wes = 0; done = 0;
        while (!done && t < 60) begin
            @(negedge clk);
            t++;
            // Request inputs are garbage while busy; only mem_en is meaningful to the initiator.
            addr_v[g] = 24'($urandom); wr_v[g] = 1'($urandom); rb_v[g] = 1'($urandom);
            if (ren_v[g]) ens++;
            if (ren_v[g] && rwe_v[g]) wes++;
            if (load_v[g]) begin
                if (strobes < nb) begin
                    check("beat_cycle", t, exp_off[strobes]);
                    check("beat_data", rdata0_v[g], exp_d[strobes]);
                end
                check("rdy_busy", rdy_v[g], 0);
                strobes++;
                if (rst_at >= 0 && strobes == rst_at) begin
                    rst_n = 1'b0;
                    en_v[g] = 1'b0;
                    #1;
                    check("rst_ram_en", ren_v[g], 0);
                    check("rst_load", load_v[g], 0);
                    check("rst_rdy", rdy_v[g], 1);
                    check("rst_rdata0", rdata0_v[g], 0);
                    check("rst_rdata", rdata_v[g], 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        @(negedge clk);
                        check("post_rst_quiet", {load_v[g], ren_v[g]}, 0);
                    end
                    return;
                end
            end else if (strobes >= nb) begin
                check("rdy_after_done", rdy_v[g], 1);
                check("rdata_reg", rdata_v[g], exp_d[nb-1]);
                check("rdata0_idle", rdata0_v[g], 0);
                done = 1;
            end
            if (strobes >= drop_at || done) en_v[g] = 1'b0;
        end
        en_v[g] = 1'b0;
        if (!done) check("txn_timeout", t, 0);
        check("strobe_count", strobes, nb);
        check("ram_access_count", ens, nb);
        check("ram_write_count", wes, wr ? 1 : 0);
        if (wr) exp_mem[g][a12] = wd;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_quiet", {load_v[g], ren_v[g]}, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        addr_v = '0; en_v = '0; wr_v = '0; rb_v = '0; wb_v = '0; wd_v = '0;
        for (int g = 0; g < NI; g++)
            for (int i = 0; i < (1 << AW); i++) exp_mem[g][i] = init_byte(g, i);

        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check("reset_rdy", rdy_v[g], 1);
            check("reset_load", load_v[g], 0);
            check("reset_ram_en", ren_v[g], 0);
            check("reset_ram_we", rwe_v[g], 0);
            check("reset_rdata", rdata_v[g], 0);
            check("reset_rdata0", rdata0_v[g], 0);
        end
        rst_n = 1'b1;

        // Directed: single write/read, aliasing via high address bits, mem_en held through completion.
        run_txn(0, 24'h001234, 1, 0, 0, 8'hA5, 99, -1);
        run_txn(0, 24'h001234, 0, 0, 0, 8'h00, 99, -1);
        run_txn(0, 24'h000010, 1, 0, 1, 8'h3C, 99, -1);
        run_txn(0, 24'hF00010, 0, 0, 0, 8'h00, 99, -1);

        // Wait-state instance: fill block 0x200 with 1..8, then a burst dropping mem_en after 7 strobes.
        for (int i = 0; i < 8; i++) run_txn(1, 24'h000200 + 24'(i), 1, 0, 0, 8'(i + 1), 99, -1);
        run_txn(1, 24'h000200, 0, 1, 0, 8'h00, 7, -1);

        // Beat-gap instance: wrapping burst from 0x205.
        for (int i = 0; i < 8; i++) run_txn(2, 24'h000200 + 24'(i), 1, 0, 0, 8'(i + 1), 99, -1);
        run_txn(2, 24'h000205, 0, 1, 0, 8'h00, 7, -1);

        // Randomized traffic, biased towards a small window so reads hit earlier writes.
        for (int n = 0; n < 90; n++) begin
            int g = n % NI;
            logic [23:0] a = 24'($urandom);
            logic wr = ($urandom_range(0, 2) == 0);
            logic bur = 1'($urandom);
            int drop = ($urandom_range(0, 1) == 0) ? 99 : $urandom_range(1, 8);
            if ($urandom_range(0, 1) == 1) a[AW-1:0] = 12'h300 + 12'($urandom_range(0, 31));
            run_txn(g, a, wr, bur, 1'($urandom), 8'($urandom), drop, -1);
        end

        // Reset mid-burst after beat 3's strobe, then a normal read.
        run_txn(2, 24'h000208, 0, 1, 0, 8'h00, 99, 4);
        run_txn(2, 24'h000203, 0, 0, 0, 8'h00, 99, -1);
        run_txn(2, 24'h00020B, 0, 1, 0, 8'h00, 99, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder_6502.md
Name: mem_responder_6502

Overview:
Memory-side responder for the byte-wide 6502 memory request interface. The initiator is the CPU-side cache controller; this block is its target.
- Accepts single-byte reads, single-byte writes and 8-beat aligned read bursts (instruction fills).
- Serves each request from a synchronous single-port byte RAM, with programmable wait states and inter-beat gaps to model slow memory.
- Returns data and completion strobes in the exact form the initiator counts: one mem_rdata_load pulse per byte, writes included.

Parameters:
ADDR_WIDTH, 16, RAM address width; mem_addr bits above ADDR_WIDTH-1 are ignored (aliasing).
WAIT_STATES, 0, idle cycles between request acceptance and first RAM access (0..15).
BEAT_GAP, 0, idle cycles inserted between successive burst beats (0..15).

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
mem_addr  in  24  request byte address
mem_en  in  1  request valid; sampled only in IDLE
mem_wr  in  1  1 = write, 0 = read
mem_rburst  in  1  read burst of 8 beats
mem_wburst  in  1  write burst request; unsupported, executes as single write
mem_wdata  in  8  write data
mem_rdy  out  1  1 when IDLE and able to accept a request
mem_rdata  out  8  registered copy of last byte delivered
mem_rdata0  out  8  data byte, valid in the mem_rdata_load cycle
mem_rdata_load  out  1  one-cycle beat/completion strobe
ram_addr  out  ADDR_WIDTH  RAM address
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable (qualified by ram_en)
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data, valid the cycle after ram_en && !ram_we

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - state = IDLE, counters = 0, mem_rdata = 0.
  - mem_rdata_load = 0, ram_en = 0, ram_we = 0, mem_rdy = 1.
  - mem_rdata0 = 0 whenever mem_rdata_load = 0.
  - Reset during any transfer aborts it: no further beats, no RAM access.
- States: IDLE, WAIT, ACCESS, GAP, DONE.
- Acceptance (cycle T):
  - In IDLE with mem_en = 1, register mem_addr, mem_wr, mem_rburst and mem_wdata.
  - mem_rdy = 0 from T+1 until the cycle after the final strobe.
  - Next state is WAIT if WAIT_STATES > 0, else ACCESS.
- Request type:
  - mem_wr = 1 is a single write; mem_rburst is ignored.
  - mem_wburst does not alter behaviour.
- Ignored inputs while not IDLE: mem_en and all other request inputs. The initiator keeps mem_en high through the completion cycle and drops it before the final burst beat; neither may cause re-acceptance or truncation.
- WAIT: count WAIT_STATES cycles, then ACCESS.
- Single read:
  - ACCESS drives ram_en = 1, ram_we = 0, ram_addr = addr[ADDR_WIDTH-1:0] at T+1+WAIT_STATES.
  - DONE at T+2+WAIT_STATES: mem_rdata_load = 1, mem_rdata0 = ram_rdata.
  - Next cycle: IDLE, mem_rdy = 1.
- Single write:
  - ACCESS at T+1+WAIT_STATES drives ram_en = 1, ram_we = 1, ram_wdata = saved wdata.
  - mem_rdata_load = 1 in the same cycle, with mem_rdata0 = saved wdata (echo).
  - Next cycle: IDLE.
- Read burst:
  - Beat k (0..7) reads address {addr[ADDR_WIDTH-1:3], (addr[2:0]+k) mod 8}, wrapping within the aligned 8-byte block.
  - RAM reads are issued back-to-back, with BEAT_GAP idle cycles (GAP state) between issues.
  - Each read's data appears on mem_rdata0 with mem_rdata_load = 1 exactly one cycle after its issue.
  - Exactly 8 strobes. Beat 0 strobe at T+2+WAIT_STATES; beat k strobe at T+2+WAIT_STATES+k*(1+BEAT_GAP).
  - A 3-bit beat counter with carry-out terminates the burst. Issue and delivery overlap when BEAT_GAP = 0.
  - The cycle after beat 7's strobe: IDLE.
- mem_rdata: on every mem_rdata_load cycle, mem_rdata <= mem_rdata0 (visible one cycle later); otherwise it holds.
- Exactly one RAM access per beat; ram_en never asserted in IDLE, WAIT or GAP.
- Back-to-back requests: minimum one IDLE cycle between consecutive transactions.

Test Plan:
- WAIT_STATES=0, RAM[0x1234]=0xA5; read at cycle T -> ram_en at T+1, mem_rdata_load with mem_rdata0=0xA5 at T+2, mem_rdata=0xA5 at T+3, mem_rdy=1 at T+3.
- Write 0x3C to 0x0010, then read 0x0010 -> write strobe at T+1 with echo 0x3C; subsequent read returns 0x3C; exactly one ram_we pulse.
- WAIT_STATES=2, BEAT_GAP=0, RAM[0x0200+i]=i+1; burst at 0x0200 with mem_en dropped after the 7th strobe -> 8 strobes on consecutive cycles T+4..T+11 carrying 0x01..0x08; IDLE at T+12.
- BEAT_GAP=1, burst at 0x0205 -> addresses 5,6,7,0,1,2,3,4 in block 0x0200; strobes spaced 2 cycles; mem_rdy=0 throughout.
- mem_en held high through a single read's completion cycle -> no second acceptance until IDLE; a new request in IDLE is accepted normally.
- rst_n low at beat 3 of a burst -> immediately ram_en=0, mem_rdata_load=0, mem_rdy=1; no further strobes after release; next read completes correctly.
